// File: rtl/mux_nx1_pipe_if.sv
// Handshake bundle for the registered N:1 operand select.
// The upstream producer and downstream consumer both sit on the master side;
// the select block itself takes the slave view.
`timescale 1ns/1ps
interface mux_nx1_pipe_if #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 2
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_zero;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_sel_err;

  modport master (
    output in_valid, in_data, in_sel, in_zero, out_ready,
    input  in_ready, out_valid, out_data, out_sel_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_zero, out_ready,
    output in_ready, out_valid, out_data, out_sel_err
  );
endinterface

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 operand select with valid/ready handshake and a 2-entry
// output FIFO. in_ready depends only on the registered count, so no
// combinational path runs from out_ready back to in_ready.
// Out-of-range selects produce zero data and raise an error flag that
// travels with the entry.
`timescale 1ns/1ps
module mux_nx1_pipe #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 2
) (
  input logic           clk,
  input logic           rst,
  mux_nx1_pipe_if.slave bus
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [DATA_W-1:0] buf_data [2];
  logic              buf_err  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic              sel_oor;
  logic [DATA_W-1:0] sel_word;
  logic [DATA_W-1:0] entry_data;
  logic              entry_err;

  assign bus.in_ready    = (count != 2'd2);
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_data    = buf_data[rd_ptr];
  assign bus.out_sel_err = buf_err[rd_ptr];

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Extend by one bit so NUM_IN itself is representable in the compare.
  assign sel_oor = ({1'b0, bus.in_sel} >= (SEL_W+1)'(NUM_IN));

  // Pick the addressed operand; an unmatched select leaves the word at zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_word = bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Form the entry to store: force-zero wins over both data and error.
  always_comb begin
    entry_data = sel_word;
    entry_err  = 1'b0;
    if (bus.in_zero) begin
      entry_data = '0;
    end else if (sel_oor) begin
      entry_data = '0;
      entry_err  = 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_err[0]  <= 1'b0;
      buf_err[1]  <= 1'b0;
    end else if (push) begin
      buf_data[wr_ptr] <= entry_data;
      buf_err[wr_ptr]  <= entry_err;
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count == 2'd2));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && count == 2'd0));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_sel_err)));
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: three instances (NUM_IN = 4, 3, 2) run in lock
// step against a queue-based reference model of the 2-deep output buffer.
`timescale 1ns/1ps
module tb_mux_nx1_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_nx1_pipe_if #(.DATA_W(32), .NUM_IN(4)) if4 ();
  mux_nx1_pipe_if #(.DATA_W(32), .NUM_IN(3)) if3 ();
  mux_nx1_pipe_if #(.DATA_W(32), .NUM_IN(2)) if2 ();

  mux_nx1_pipe #(.DATA_W(32), .NUM_IN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  mux_nx1_pipe #(.DATA_W(32), .NUM_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  mux_nx1_pipe #(.DATA_W(32), .NUM_IN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Stimulus per instance: index 0 -> NUM_IN=4, 1 -> NUM_IN=3, 2 -> NUM_IN=2.
  logic        iv   [3];
  logic [1:0]  isel [3];
  logic        iz   [3];
  logic        ord  [3];
  logic [31:0] opd  [3][4];

  logic        o_valid [3];
  logic        o_rdy   [3];
  logic        o_err   [3];
  logic [31:0] o_data  [3];

  assign if4.in_valid  = iv[0];
  assign if4.in_sel    = isel[0];
  assign if4.in_zero   = iz[0];
  assign if4.out_ready = ord[0];
  assign if4.in_data   = {opd[0][3], opd[0][2], opd[0][1], opd[0][0]};
  assign if3.in_valid  = iv[1];
  assign if3.in_sel    = isel[1];
  assign if3.in_zero   = iz[1];
  assign if3.out_ready = ord[1];
  assign if3.in_data   = {opd[1][2], opd[1][1], opd[1][0]};
  assign if2.in_valid  = iv[2];
  assign if2.in_sel    = isel[2][0];
  assign if2.in_zero   = iz[2];
  assign if2.out_ready = ord[2];
  assign if2.in_data   = {opd[2][1], opd[2][0]};

  assign o_valid[0] = if4.out_valid;
  assign o_rdy[0]   = if4.in_ready;
  assign o_err[0]   = if4.out_sel_err;
  assign o_data[0]  = if4.out_data;
  assign o_valid[1] = if3.out_valid;
  assign o_rdy[1]   = if3.in_ready;
  assign o_err[1]   = if3.out_sel_err;
  assign o_data[1]  = if3.out_data;
  assign o_valid[2] = if2.out_valid;
  assign o_rdy[2]   = if2.in_ready;
  assign o_err[2]   = if2.out_sel_err;
  assign o_data[2]  = if2.out_data;

  // Reference model: each queue holds {err, data}, front is the head.
  logic [32:0] q [3][$];
  bit          last_acc [3];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int nin(input int d);
    return (d == 0) ? 4 : (d == 1) ? 3 : 2;
  endfunction

  function automatic logic [32:0] expect_entry(input int d);
    int s;
    s = (d == 2) ? int'(isel[d][0]) : int'(isel[d]);
    if (iz[d]) return 33'd0;
    if (s >= nin(d)) return {1'b1, 32'd0};
    return {1'b0, opd[d][s]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input string tag);
    chk($sformatf("%s.in_ready[%0d]", tag, d), 64'(o_rdy[d]), 64'(q[d].size() < 2));
    chk($sformatf("%s.out_valid[%0d]", tag, d), 64'(o_valid[d]), 64'(q[d].size() > 0));
    if (q[d].size() > 0) begin
      chk($sformatf("%s.out_data[%0d]", tag, d), 64'(o_data[d]), 64'(q[d][0][31:0]));
      chk($sformatf("%s.out_sel_err[%0d]", tag, d), 64'(o_err[d]), 64'(q[d][0][32]));
    end
  endtask

  // One clock: model decides accept/pop from pre-edge state, then compares.
  task automatic tick(input string tag);
    bit          acc [3];
    bit          pp  [3];
    logic [32:0] e   [3];
    for (int d = 0; d < 3; d++) begin
      acc[d] = iv[d] && (q[d].size() < 2);
      pp[d]  = (q[d].size() > 0) && ord[d];
      e[d]   = expect_entry(d);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (pp[d])  void'(q[d].pop_front());
      if (acc[d]) q[d].push_back(e[d]);
      last_acc[d] = acc[d];
      check_dut(d, tag);
    end
  endtask

  task automatic chk_reset_outputs(input string tag, input bit with_ready);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.out_valid[%0d]", tag, d), 64'(o_valid[d]), 64'd0);
      chk($sformatf("%s.out_data[%0d]", tag, d), 64'(o_data[d]), 64'd0);
      chk($sformatf("%s.out_sel_err[%0d]", tag, d), 64'(o_err[d]), 64'd0);
      if (with_ready) chk($sformatf("%s.in_ready[%0d]", tag, d), 64'(o_rdy[d]), 64'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bp [3];
    logic [31:0] got [$];
    int          idx;
    int          acc_cnt;
    logic [31:0] x;

    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; isel[d] = 2'd0; iz[d] = 1'b0; ord[d] = 1'b1;
      for (int k = 0; k < 4; k++) opd[d][k] = 32'd0;
    end

    // Power-on reset.
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold", 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_release", 1'b1);

    // Basic select on the 4-input instance.
    opd[0][3] = 32'h44444444; opd[0][2] = 32'h33333333;
    opd[0][1] = 32'h22222222; opd[0][0] = 32'h11111111;
    iv[0] = 1'b1; isel[0] = 2'd2;
    tick("basic");
    chk("basic_value", 64'(o_data[0]), 64'h33333333);
    chk("basic_err", 64'(o_err[0]), 64'd0);
    iv[0] = 1'b0;
    tick("basic_drain");

    // Streaming: 8 back-to-back beats, out_ready held high.
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; isel[0] = 2'(i % 4); opd[0][i % 4] = $urandom;
      tick("stream");
      if (last_acc[0]) acc_cnt++;
    end
    chk("stream_accepts", 64'(acc_cnt), 64'd8);
    iv[0] = 1'b0;
    tick("stream_drain");

    // Back-pressure: three beats against a stalled consumer.
    bp[0] = 32'hA0A0A0A0; bp[1] = 32'hB1B1B1B1; bp[2] = 32'hC2C2C2C2;
    ord[0] = 1'b0; isel[0] = 2'd1; idx = 0;
    for (int c = 0; c < 4; c++) begin
      iv[0] = (idx < 3); opd[0][1] = bp[idx < 3 ? idx : 2];
      tick("bp_stall");
      if (last_acc[0]) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(o_rdy[0]), 64'd0);
    chk("bp_head", 64'(o_data[0]), 64'(bp[0]));
    ord[0] = 1'b1;
    for (int c = 0; c < 10 && (idx < 3 || q[0].size() > 0); c++) begin
      iv[0] = (idx < 3); opd[0][1] = bp[idx < 3 ? idx : 2];
      if (o_valid[0]) got.push_back(o_data[0]);
      tick("bp_drain");
      if (last_acc[0]) idx++;
    end
    iv[0] = 1'b0;
    chk("bp_out_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("bp_order[%0d]", i), 64'(got[i]), 64'(bp[i]));

    // Error and force-zero on the 3-input instance.
    for (int k = 0; k < 3; k++) opd[1][k] = $urandom | 32'h1;
    iv[1] = 1'b1; isel[1] = 2'd3; iz[1] = 1'b0;
    tick("err_sel");
    chk("err_data", 64'(o_data[1]), 64'd0);
    chk("err_flag", 64'(o_err[1]), 64'd1);
    isel[1] = 2'd1; iz[1] = 1'b1;
    tick("zero_mode");
    chk("zero_data", 64'(o_data[1]), 64'd0);
    chk("zero_flag", 64'(o_err[1]), 64'd0);
    iv[1] = 1'b0; iz[1] = 1'b0;
    tick("err_drain");

    // Default-parameter instance.
    opd[2][0] = 32'hDEADBEEF; opd[2][1] = 32'h12345678;
    iv[2] = 1'b1; isel[2] = 2'd1;
    tick("dflt_sel1");
    chk("dflt_b", 64'(o_data[2]), 64'h12345678);
    isel[2] = 2'd0;
    tick("dflt_sel0");
    chk("dflt_a", 64'(o_data[2]), 64'hDEADBEEF);
    iv[2] = 1'b0;
    tick("dflt_drain");

    // Reset in the middle of a stalled stream.
    ord[0] = 1'b0; iv[0] = 1'b1; isel[0] = 2'd0;
    opd[0][0] = $urandom; tick("mid_fill");
    opd[0][0] = $urandom; tick("mid_fill");
    iv[0] = 1'b0;
    chk("mid_buffered", 64'(q[0].size()), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid", 1'b0);
    for (int d = 0; d < 3; d++) q[d].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_release", 1'b1);
    ord[0] = 1'b1; iv[0] = 1'b1;
    x = $urandom; opd[0][0] = x;
    tick("post_rst");
    chk("post_rst_data", 64'(o_data[0]), 64'(x));
    iv[0] = 1'b0;
    tick("post_rst_drain");

    // Randomised traffic on all three instances.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = ($urandom % 4) != 0;
        isel[d] = (d == 2) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        iz[d]   = ($urandom % 8) == 0;
        ord[d]  = ($urandom % 3) != 0;
        for (int k = 0; k < 4; k++) opd[d][k] = $urandom;
      end
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
